// File: rtl/pipe_skid_reg.sv
// Elastic stage-boundary register: valid/ready handshake with a 2-entry skid
// buffer, global freeze, synchronous flush and a saturating stall-cycle counter.
module pipe_skid_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and ready here depends only on
  // registered state plus stall/flush, never on out_ready.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  main_data_q, main_data_d;
  logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]  skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_fire, out_fire;

  assign in_ready     = (state_q != S_TWO) && !stall && !flush;
  assign out_valid    = (state_q != S_EMPTY) && !stall && !flush;
  assign out_data     = main_data_q;
  assign out_ctrl     = out_valid ? main_ctrl_q : '0;
  assign occupancy    = state_q;
  assign stall_cycles = cnt_q;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    cnt_d       = cnt_q;
    if (flush) begin
      // Bubbles must carry no control; data is left as-is.
      state_d     = S_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else if (stall) begin
      if (state_q != S_EMPTY && cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d     = S_ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
            state_d     = S_TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (out_fire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            state_d     = S_ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios then random traffic, checked
// against a queue-based model of the stage.
module tb_pipe_skid_reg;
  localparam int DW = 32;
  localparam int CW = 3;
  localparam int NW = 4;
  localparam int CNT_MAX = (1 << NW) - 1;

  logic          clk, rst, stall, flush;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occupancy;
  logic [NW-1:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  // Model: FIFO of {ctrl,data} entries and the stall counter value.
  logic [DW+CW-1:0] exp_q[$];
  int               exp_cnt = 0;

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int  occ;
    bit  ev;
    occ = exp_q.size();
    ev  = (occ > 0) && !stall && !flush;
    check("occupancy", 32'(occupancy), 32'(occ));
    check("in_ready", 32'(in_ready), 32'((occ < 2) && !stall && !flush));
    check("out_valid", 32'(out_valid), 32'(ev));
    check("stall_cycles", 32'(stall_cycles), 32'(exp_cnt));
    if (ev) begin
      check("out_data", out_data, exp_q[0][DW-1:0]);
      check("out_ctrl", 32'(out_ctrl), 32'(exp_q[0][DW+CW-1:DW]));
    end else begin
      check("out_ctrl_bubble", 32'(out_ctrl), 32'd0);
    end
  endtask

  // Called just after a falling edge: drive, check, cross one rising edge.
  task automatic cycle(input bit iv, input logic [DW-1:0] id, input logic [CW-1:0] ic,
                       input bit ordy, input bit st, input bit fl);
    bit ifire, ofire;
    in_valid = iv; in_data = id; in_ctrl = ic;
    out_ready = ordy; stall = st; flush = fl;
    #1;
    check_outputs();
    ifire = iv && (exp_q.size() < 2) && !st && !fl;
    ofire = ordy && (exp_q.size() > 0) && !st && !fl;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else if (st) begin
      if (exp_q.size() > 0 && exp_cnt < CNT_MAX) exp_cnt++;
    end else begin
      if (ofire) void'(exp_q.pop_front());
      if (ifire) exp_q.push_back({ic, id});
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 0; flush = 0; in_valid = 0; out_ready = 0;
    in_data = '0; in_ctrl = '0;
    #3;
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Streaming
    cycle(1, 32'h11, 3'd1, 1, 0, 0);
    cycle(1, 32'h22, 3'd2, 1, 0, 0);
    cycle(1, 32'h33, 3'd3, 1, 0, 0);
    cycle(0, 32'h0,  3'd0, 1, 0, 0);
    cycle(0, 32'h0,  3'd0, 1, 0, 0);

    // Backpressure
    cycle(1, 32'hA, 3'd1, 0, 0, 0);
    cycle(1, 32'hB, 3'd2, 0, 0, 0);
    cycle(1, 32'hC, 3'd3, 0, 0, 0);
    cycle(1, 32'hC, 3'd3, 1, 0, 0);
    cycle(1, 32'hC, 3'd3, 1, 0, 0);
    cycle(0, 32'h0, 3'd0, 1, 0, 0);
    cycle(0, 32'h0, 3'd0, 1, 0, 0);

    // Stall with one entry holding ctrl 101
    cycle(1, 32'h55, 3'b101, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 32'h0, 3'd0, 1, 1, 0);
    check("stall_cnt_5", 32'(stall_cycles), 32'd5);
    cycle(0, 32'h0, 3'd0, 1, 0, 0);

    // Flush overriding stall with two entries held
    cycle(1, 32'h66, 3'd6, 0, 0, 0);
    cycle(1, 32'h77, 3'd7, 0, 0, 0);
    cycle(0, 32'h0, 3'd0, 0, 1, 1);
    check("flush_cnt_held", 32'(stall_cycles), 32'd5);
    cycle(1, 32'h44, 3'd4, 1, 0, 0);
    cycle(0, 32'h0, 3'd0, 1, 0, 0);

    // Saturation
    cycle(1, 32'h88, 3'd2, 0, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 32'h0, 3'd0, 0, 1, 0);
    check("stall_cnt_sat", 32'(stall_cycles), 32'd15);

    // Async reset with two entries held
    cycle(1, 32'h99, 3'd1, 0, 0, 0);
    in_valid = 0; out_ready = 0; stall = 0; flush = 0;
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    exp_cnt = 0;
    check("arst_occ", 32'(occupancy), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_cnt", 32'(stall_cycles), 32'd0);
    check("arst_out_ctrl", 32'(out_ctrl), 32'd0);
    check("arst_out_data", out_data, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 32'hBEEF, 3'd3, 1, 0, 0);
    cycle(0, 32'h0, 3'd0, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 1)), $urandom, 3'($urandom),
            bit'($urandom_range(0, 2) != 0),
            $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
